// File: rtl/pe_port_scheduler_pkg.sv
// Shared definitions for the memory-port scheduler: opcode encoding and requester-ID sizing.
package pe_port_scheduler_pkg;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  localparam int PROCESSING_ENGINES_DEFAULT = 4;

  // An ID field is never narrower than one bit, even for a single requester.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int PE_ID_W = id_width(PROCESSING_ENGINES_DEFAULT);

endpackage

// File: rtl/pe_port_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after ptr, wrapping; zero latency.
// No backpressure of its own; ungranted requesters simply stay pending.
module rr_arbiter #(
  parameter int PE   = 4,
  parameter int ID_W = 2
) (
  input  logic [PE-1:0]   req_valid,
  input  logic [ID_W-1:0] ptr,
  output logic [PE-1:0]   grant,
  output logic [ID_W-1:0] grant_idx,
  output logic            grant_any
);

  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 0; k < PE; k++) begin
      idx = (int'(ptr) + k) % PE;
      if (!grant_any && req_valid[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
        grant_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pe_port_scheduler.sv
// Shares one key/value memory port among requesters; grant->port 1 cycle, grant->read response read_latency+2.
// Backpressure: at most one combinational req_ready per cycle; ungranted requests hold until served.
module pe_port_scheduler
  import pe_port_scheduler_pkg::*;
#(
  parameter int index_width        = 8,
  parameter int data_width         = 64,
  parameter int processing_engines = 4,
  parameter int read_latency       = 2
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [processing_engines-1:0]            req_valid,
  input  logic [processing_engines-1:0]            req_wen,
  input  logic [processing_engines*index_width-1:0] req_addr,
  input  logic [processing_engines*data_width-1:0]  req_kandv,
  output logic [processing_engines-1:0]            req_ready,
  output logic                                     port_wen,
  output logic                                     port_ren,
  output logic [index_width-1:0]                   port_addr,
  output logic [data_width-1:0]                    port_kandv,
  input  logic [data_width-1:0]                    port_rdata,
  output logic [processing_engines-1:0]            resp_valid,
  output logic [data_width-1:0]                    resp_kandv,
  output logic                                     busy
);

  localparam int ID_W = id_width(processing_engines);

  logic [ID_W-1:0]               ptr;
  logic [ID_W-1:0]               grant_idx;
  logic [ID_W-1:0]               port_id;
  logic [processing_engines-1:0] grant;
  logic                          grant_any;
  logic                          sel_wen;
  logic [index_width-1:0]        sel_addr;
  logic [data_width-1:0]         sel_kandv;

  rr_arbiter #(
    .PE   (processing_engines),
    .ID_W (ID_W)
  ) u_arb (
    .req_valid (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign req_ready = reset ? grant : '0;

  assign sel_wen   = req_wen[grant_idx];
  assign sel_addr  = req_addr[grant_idx*index_width +: index_width];
  assign sel_kandv = req_kandv[grant_idx*data_width +: data_width];

  // Issue stage: address/data only move on a grant so idle cycles keep the last values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      port_wen   <= 1'b0;
      port_ren   <= 1'b0;
      port_addr  <= '0;
      port_kandv <= '0;
      port_id    <= '0;
      ptr        <= '0;
    end else begin
      port_wen <= grant_any && (sel_wen == OP_WRITE);
      port_ren <= grant_any && (sel_wen == OP_READ);
      if (grant_any) begin
        port_addr  <= sel_addr;
        port_kandv <= sel_kandv;
        port_id    <= grant_idx;
        ptr        <= (grant_idx == ID_W'(processing_engines - 1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  // Tag stage k holds the read issued k+1 cycles ago; the last stage lines up with port_rdata.
  logic [read_latency-1:0] tag_vld;
  logic [ID_W-1:0]         tag_id [read_latency];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_vld <= '0;
      for (int k = 0; k < read_latency; k++) tag_id[k] <= '0;
    end else begin
      tag_vld[0] <= port_ren;
      tag_id[0]  <= port_id;
      for (int k = 1; k < read_latency; k++) begin
        tag_vld[k] <= tag_vld[k-1];
        tag_id[k]  <= tag_id[k-1];
      end
    end
  end

  logic [processing_engines-1:0] resp_onehot;

  always_comb begin
    resp_onehot = '0;
    resp_onehot[tag_id[read_latency-1]] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_valid <= '0;
      resp_kandv <= '0;
    end else begin
      resp_valid <= tag_vld[read_latency-1] ? resp_onehot : '0;
      if (tag_vld[read_latency-1]) resp_kandv <= port_rdata;
    end
  end

  assign busy = port_wen | port_ren | (|tag_vld);

endmodule
